pkt_rr_arbiter: RTL
===================

# pkt_rr_arbiter

Packet-granular round-robin arbiter that merges NUM_INPUTS AXI-Stream sources into one stream feeding the NMU packet buffer input. A grant is held from the first beat of a packet until its tlast beat is accepted, so packets from different sources never interleave. Output is fully registered, which isolates the buffer's tready path from the upstream sources.

## Interface
- AXIS_BUS_WIDTH, 64: tdata width in bits; tkeep is AXIS_BUS_WIDTH/8.
- AXIS_ID_WIDTH, 4: tdest is AXIS_ID_WIDTH+1 bits.
- NUM_INPUTS, 4: number of sources, 2..16.
- aclk  in  1  sole clock; all logic on the rising edge.
- aresetn  in  1  reset, asynchronous assert, active-low.
- axis_in_tdata  in  NUM_INPUTS*AXIS_BUS_WIDTH  flattened; source i occupies slice i.
- axis_in_tuser  in  NUM_INPUTS*2  per-source {parsing_done, poisoned}, forwarded unchanged.
- axis_in_tdest  in  NUM_INPUTS*(AXIS_ID_WIDTH+1)  per-source destination.
- axis_in_tkeep  in  NUM_INPUTS*AXIS_BUS_WIDTH/8  per-source byte enables.
- axis_in_tlast  in  NUM_INPUTS  per-source end of packet.
- axis_in_tvalid  in  NUM_INPUTS  per-source valid.
- axis_in_tready  out  NUM_INPUTS  per-source ready.
- axis_out_tdata / tuser / tdest / tkeep / tlast / tvalid  out  matching single-source widths  merged registered stream.
- axis_out_tready  in  1  downstream ready.
- grant_onehot  out  NUM_INPUTS  current owner; 0 when no source owns the output.

## Operation
- FSM states: ARB and PASS. Reset state is ARB.
- ARB:
  - If any tvalid is high, select the first requesting index in circular order starting at last_grant+1.
  - Register the grant and last_grant, then move to PASS.
  - If no tvalid is high, stay in ARB.
  - All axis_in_tready are 0 in ARB.
- PASS:
  - axis_in_tready[g] = !out_valid_q || axis_out_tready. All other readies are 0.
  - An accepted beat loads the output register with tdata, tuser, tdest, tkeep and tlast from source g, and sets out_valid_q.
  - When a tlast beat from g is accepted, grant_onehot clears and the FSM returns to ARB.
  - tvalid may drop mid-packet. The grant is held with no timeout.
- Output register:
  - out_valid_q clears when the output accepts a beat and no new beat is loaded in the same cycle.
  - It may hold its last beat while the FSM is already in ARB.
- Pointer arithmetic:
  - last_grant is a $clog2(NUM_INPUTS)-bit index.
  - Wrap from NUM_INPUTS-1 to 0 is explicit, so non-power-of-2 NUM_INPUTS is supported.
- Reset values:
  - out_valid_q = 0; all output data/tuser/tdest/tkeep/tlast = 0.
  - grant_onehot = 0; all axis_in_tready = 0; FSM = ARB.
  - last_grant = NUM_INPUTS-1, so source 0 wins first.
- Reset mid-packet:
  - Outputs drop to reset values immediately.
  - The partial packet is abandoned; no tlast is emitted.

## Timing
- Arbitration takes 1 cycle: a request seen in ARB at cycle N gives tready at cycle N+1.
- Pipeline latency is 1 cycle: a beat accepted at cycle N is on the output at N+1.
- First beat of an idle-arbiter packet appears at N+2 after tvalid rises at N.
- Each packet end costs one ARB bubble cycle, so throughput is L/(L+1) beats per cycle for L-beat packets.
- Full throughput holds within a packet when axis_out_tready stays high.
- Single-beat packet (tlast on first beat): PASS lasts exactly 1 cycle.
- No combinational path from axis_in_tvalid to axis_in_tready. The only combinational path is axis_out_tready to axis_in_tready.

## Configuration
- Macro: PKT_RR_ARBITER_STATS_EN.
- Defined:
  - Adds output port stat_pkt_count, NUM_INPUTS*32 bits.
  - Slice i increments when a tlast beat from source i is accepted.
  - Counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined:
  - Port and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then source 0 sends a 3-beat packet with tdest 5 and tready held 1. Required: beats on output at cycles 2, 3, 4; tdest 5 on every beat; tlast only on beat 3.
- All 4 sources continuously send 2-beat packets. Required: output order 0,1,2,3,0,1; exactly one idle cycle between packets; no interleaving.
- Source 2 alone sends back-to-back 1-beat packets. Required: each is granted to source 2; output valid in every other cycle.
- Source 1 granted; its tvalid drops for 4 cycles mid-packet while source 3 requests. Required: grant stays on source 1; source 3 served only after source 1's tlast.
- axis_out_tready toggles 1010 during a 4-beat packet. Required: no beat lost or duplicated; tdata sequence matches input; tuser/tkeep preserved.
- aresetn pulsed low mid-packet (with PKT_RR_ARBITER_STATS_EN defined). Required: tvalid 0 immediately and stat_pkt_count 0. Next grant goes to source 0; after 3 completed packets from source 0, its count reads 3.

Source files
------------

// File: rtl/pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pkt_rr_arbiter
// Brief    : Packet-granular round-robin merge of NUM_INPUTS AXI-Stream sources
//            into one fully registered output stream. Optional per-source
//            packet counters are enabled by PKT_RR_ARBITER_STATS_EN.
// Revision : 1.0
// ============================================================================
module pkt_rr_arbiter #(
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_ID_WIDTH  = 4,
  parameter int NUM_INPUTS     = 4
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic [NUM_INPUTS*AXIS_BUS_WIDTH-1:0]   axis_in_tdata,
  input  logic [NUM_INPUTS*2-1:0]                axis_in_tuser,
  input  logic [NUM_INPUTS*(AXIS_ID_WIDTH+1)-1:0] axis_in_tdest,
  input  logic [NUM_INPUTS*AXIS_BUS_WIDTH/8-1:0] axis_in_tkeep,
  input  logic [NUM_INPUTS-1:0]                  axis_in_tlast,
  input  logic [NUM_INPUTS-1:0]                  axis_in_tvalid,
  output logic [NUM_INPUTS-1:0]                  axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]              axis_out_tdata,
  output logic [1:0]                             axis_out_tuser,
  output logic [AXIS_ID_WIDTH:0]                 axis_out_tdest,
  output logic [AXIS_BUS_WIDTH/8-1:0]            axis_out_tkeep,
  output logic                                   axis_out_tlast,
  output logic                                   axis_out_tvalid,
  input  logic                                   axis_out_tready,
`ifdef PKT_RR_ARBITER_STATS_EN
  output logic [NUM_INPUTS*32-1:0]               stat_pkt_count,
`endif
  output logic [NUM_INPUTS-1:0]                  grant_onehot
);

  localparam int c_KW = AXIS_BUS_WIDTH / 8;
  localparam int c_DW = AXIS_ID_WIDTH + 1;
  localparam int c_IW = $clog2(NUM_INPUTS);
  localparam logic [c_IW:0]         c_NUM = (c_IW+1)'(NUM_INPUTS);
  localparam logic [c_IW-1:0]       c_LAST_INIT = c_IW'(NUM_INPUTS - 1);
  localparam logic [NUM_INPUTS-1:0] c_ONE = {{(NUM_INPUTS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_PASS = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [c_IW-1:0]           last_grant_q, last_grant_d;
  logic [NUM_INPUTS-1:0]     grant_q, grant_d;
  logic                      out_valid_q, out_valid_d;
  logic [AXIS_BUS_WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]                out_user_q, out_user_d;
  logic [c_DW-1:0]           out_dest_q, out_dest_d;
  logic [c_KW-1:0]           out_keep_q, out_keep_d;
  logic                      out_last_q, out_last_d;

  logic                      pick_found;
  logic [c_IW-1:0]           pick_idx;
  logic [c_IW:0]             cand;

  logic                      sel_valid;
  logic [AXIS_BUS_WIDTH-1:0] sel_data;
  logic [1:0]                sel_user;
  logic [c_DW-1:0]           sel_dest;
  logic [c_KW-1:0]           sel_keep;
  logic                      sel_last;

  logic                      slot_free;
  logic                      beat_acc;

  // Circular search from last_grant+1; the wrap is explicit so any NUM_INPUTS works.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_grant_q;
    cand       = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand = {1'b0, last_grant_q} + (c_IW+1)'(k);
      if (cand >= c_NUM) begin
        cand = cand - c_NUM;
      end
      if (!pick_found && axis_in_tvalid[cand[c_IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[c_IW-1:0];
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_user  = '0;
    sel_dest  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_q[i]) begin
        sel_valid = sel_valid | axis_in_tvalid[i];
        sel_data  = sel_data  | axis_in_tdata[i*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
        sel_user  = sel_user  | axis_in_tuser[i*2 +: 2];
        sel_dest  = sel_dest  | axis_in_tdest[i*c_DW +: c_DW];
        sel_keep  = sel_keep  | axis_in_tkeep[i*c_KW +: c_KW];
        sel_last  = sel_last  | axis_in_tlast[i];
      end
    end
  end

  // Downstream ready is the only combinational contributor to upstream ready.
  assign slot_free = !out_valid_q || axis_out_tready;
  assign beat_acc  = (state_q == ST_PASS) && sel_valid && slot_free;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    grant_d        = grant_q;
    out_valid_d    = out_valid_q && !axis_out_tready;
    out_data_d     = out_data_q;
    out_user_d     = out_user_q;
    out_dest_d     = out_dest_q;
    out_keep_d     = out_keep_q;
    out_last_d     = out_last_q;
    axis_in_tready = '0;
    case (state_q)
      ST_ARB: begin
        if (pick_found) begin
          state_d      = ST_PASS;
          last_grant_d = pick_idx;
          grant_d      = c_ONE << pick_idx;
        end
      end
      ST_PASS: begin
        axis_in_tready = grant_q & {NUM_INPUTS{slot_free}};
        if (beat_acc) begin
          out_valid_d = 1'b1;
          out_data_d  = sel_data;
          out_user_d  = sel_user;
          out_dest_d  = sel_dest;
          out_keep_d  = sel_keep;
          out_last_d  = sel_last;
          if (sel_last) begin
            grant_d = '0;
            state_d = ST_ARB;
          end
        end
      end
      default: begin
        state_d = ST_ARB;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_ARB;
      last_grant_q <= c_LAST_INIT;
      grant_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_user_q   <= '0;
      out_dest_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_user_q   <= out_user_d;
      out_dest_q   <= out_dest_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
    end
  end

  assign axis_out_tvalid = out_valid_q;
  assign axis_out_tdata  = out_data_q;
  assign axis_out_tuser  = out_user_q;
  assign axis_out_tdest  = out_dest_q;
  assign axis_out_tkeep  = out_keep_q;
  assign axis_out_tlast  = out_last_q;
  assign grant_onehot    = grant_q;

`ifdef PKT_RR_ARBITER_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_stats
      logic [31:0] cnt_q, cnt_d;
      always_comb begin
        cnt_d = cnt_q;
        if (beat_acc && sel_last && grant_q[gi] && (cnt_q != 32'hFFFF_FFFF)) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
      assign stat_pkt_count[gi*32 +: 32] = cnt_q;
    end
  endgenerate
`endif

endmodule
`default_nettype wire
